wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Writeback-stage consumer of the MEM/WB pipeline register.
//  - Selects the writeback result from the W-stage fields: ALU result, load data or PC+4.
//  - Commits that result into the 32-entry integer register file.
//  - Serves the two decode-stage read ports.
//  - Counts retired instructions.
//  Sits between the MEM/WB register (W-side outputs) and the ID stage operand fetch.
// PARAMETERS
//  XLEN     32  data width of registers, results and read ports
//  CNT_W    64  width of the retired-instruction counter
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        asynchronous, active-low reset
//  ValidW      in   1        W-stage holds a real instruction (0 = bubble)
//  RegWriteW   in   1        W-stage instruction writes rd
//  ResultSrcW  in   2        writeback select: 00 ALU, 01 load, 10 PC+4, 11 ALU
//  Adder4W     in   XLEN     PC+4 of the W-stage instruction
//  ALUResultW  in   XLEN     ALU result
//  ReadDataW   in   XLEN     load data
//  RDW         in   5        destination register index
//  RS1D        in   5        decode read port 1 index
//  RS2D        in   5        decode read port 2 index
//  RD1D        out  XLEN     read port 1 data
//  RD2D        out  XLEN     read port 2 data
//  ResultW     out  XLEN     selected writeback value (feeds EX forwarding)
//  InstRetW    out  CNT_W    retired-instruction count
// BEHAVIOUR
//  - Reset (rst=0, async): x1..x31 <= 0; InstRetW <= 0. ResultW and RDxD are combinational and follow the inputs.
//  - ResultW is combinational:
//    - 00 -> ALUResultW; 01 -> ReadDataW; 10 -> Adder4W; 11 -> ALUResultW (reserved encoding).
//  - Write enable: we = ValidW & RegWriteW & (RDW != 0).
//    - When we=1, regs[RDW] <= ResultW on the rising clk edge.
//    - Latency: 1 cycle from W-stage presentation to architectural state.
//  - x0 is hardwired 0: never stored; reads of index 0 return 0 regardless of writes or bypass.
//  - Reads are combinational, with zero-cycle latency: RD1D = regs[RS1D], RD2D = regs[RS2D].
//  - Both read ports may address the same register or RDW simultaneously; there is no port conflict.
//  - InstRetW increments by 1 on each rising edge with ValidW=1 (independent of RegWriteW).
//    - Wraps from 2^CNT_W-1 to 0 silently. Bubbles do not count.
//  - Reset asserted mid-cycle overrides any pending write; the first write is accepted on the first edge after rst returns high.
//  - Inputs are sampled only on clk; no handshake is needed, since MEM/WB delivers one entry per cycle.
// CONFIGURATION
//  - REGFILE_BYPASS_EN defined:
//    - Write-through read: if we=1 and RSxD==RDW (nonzero), RDxD = ResultW in the same cycle.
//    - The ID stage sees the value being written back in that cycle.
//  - REGFILE_BYPASS_EN undefined:
//    - RDxD returns the stored (old) value during the write cycle.
//    - The new value is visible from the next cycle. The hazard unit must stall or forward.
// TESTING
//  - Reset: drive rst=0 after writes -> every RS1D/RS2D in 0..31 reads 0; InstRetW=0.
//  - Write/read: ValidW=1, RegWriteW=1, ResultSrcW=00, ALUResultW=0xDEADBEEF, RDW=5 -> next cycle RS1D=5 reads 0xDEADBEEF.
//  - Mux: ResultSrcW=01 with ReadDataW=0x12345678, RDW=7 -> x7=0x12345678; ResultSrcW=10 with Adder4W=0x104, RDW=1 -> x1=0x104.
//  - x0 and bubble:
//    - RDW=0 with write -> RD1D(RS1D=0)=0.
//    - ValidW=0, RegWriteW=1, RDW=3 -> x3 unchanged; InstRetW unchanged.
//  - Same-cycle read of RDW=9, ResultW=0xA5A5A5A5, x9 previously 0x1:
//    - REGFILE_BYPASS_EN defined -> RD2D=0xA5A5A5A5.
//    - REGFILE_BYPASS_EN undefined -> RD2D=0x1, then 0xA5A5A5A5 next cycle.
//  - Counter: 10 cycles ValidW=1 interleaved with 3 bubbles -> InstRetW=10.
//    - CNT_W=4 with 17 valid cycles -> InstRetW=1 (wrap).

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage: result select, 32 x XLEN integer register file with two decode read ports,
// and retired-instruction counter. Define REGFILE_BYPASS_EN for write-through reads.
module wb_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidW,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcW,
    input  logic [XLEN-1:0]  Adder4W,
    input  logic [XLEN-1:0]  ALUResultW,
    input  logic [XLEN-1:0]  ReadDataW,
    input  logic [4:0]       RDW,
    input  logic [4:0]       RS1D,
    input  logic [4:0]       RS2D,
    output logic [XLEN-1:0]  RD1D,
    output logic [XLEN-1:0]  RD2D,
    output logic [XLEN-1:0]  ResultW,
    output logic [CNT_W-1:0] InstRetW
);

    logic [XLEN-1:0] regs [32];
    logic            we;

    always_comb begin
        case (ResultSrcW)
            2'b01:   ResultW = ReadDataW;
            2'b10:   ResultW = Adder4W;
            default: ResultW = ALUResultW;
        endcase
    end

    always_comb begin
        we = ValidW & RegWriteW & (RDW != 5'd0);
    end

    // Entry 0 is reset and never written; reads of index 0 are forced to zero anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs     <= '{default: '0};
            InstRetW <= '0;
        end else begin
            if (we) begin
                regs[RDW] <= ResultW;
            end
            if (ValidW) begin
                InstRetW <= InstRetW + CNT_W'(1);
            end
        end
    end

    always_comb begin
        RD1D = '0;
        RD2D = '0;
        if (RS1D != 5'd0) begin
            RD1D = regs[RS1D];
        end
        if (RS2D != 5'd0) begin
            RD2D = regs[RS2D];
        end
`ifdef REGFILE_BYPASS_EN
        // we already excludes RDW==0, so x0 can never be bypassed.
        if (we && (RS1D == RDW)) begin
            RD1D = ResultW;
        end
        if (we && (RS2D == RDW)) begin
            RD2D = ResultW;
        end
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table plus scoreboard, with reset and counter-wrap sequences.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        ValidW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] Adder4W;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RDW;
    logic [4:0]  RS1D;
    logic [4:0]  RS2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic [63:0] InstRetW;
    logic [31:0] s_rd1;
    logic [31:0] s_rd2;
    logic [31:0] s_res;
    logic [3:0]  s_cnt;

    wb_regfile #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .Adder4W(Adder4W), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RDW(RDW), .RS1D(RS1D), .RS2D(RS2D),
        .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .InstRetW(InstRetW)
    );

    wb_regfile #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .Adder4W(Adder4W), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RDW(RDW), .RS1D(RS1D), .RS2D(RS2D),
        .RD1D(s_rd1), .RD2D(s_rd2), .ResultW(s_res), .InstRetW(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic        rw;
        logic [1:0]  src;
        logic [31:0] adder4;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp_res;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [63:0] cnt;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    logic [31:0] mregs [32];
    logic [63:0] mcnt;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mcnt = 64'h0;
    endtask

    function automatic logic [31:0] mread(input logic [4:0] rs, input vec_t v);
        logic we;
        we = v.v && v.rw && (v.rd != 5'd0);
        if (rs == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && rs == v.rd) return v.exp_res;
`endif
        return mregs[rs];
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        ValidW = v.v; RegWriteW = v.rw; ResultSrcW = v.src;
        Adder4W = v.adder4; ALUResultW = v.alu; ReadDataW = v.rdata;
        RDW = v.rd; RS1D = v.rs1; RS2D = v.rs2;
        e.name = v.name;
        e.res  = v.exp_res;
        e.rd1  = mread(v.rs1, v);
        e.rd2  = mread(v.rs2, v);
        e.cnt  = mcnt;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, ".res"}, {32'h0, ResultW}, {32'h0, e.res});
        chk({e.name, ".rd1"}, {32'h0, RD1D}, {32'h0, e.rd1});
        chk({e.name, ".rd2"}, {32'h0, RD2D}, {32'h0, e.rd2});
        chk({e.name, ".cnt"}, InstRetW, e.cnt);
        chk({e.name, ".cnt4"}, {60'h0, s_cnt}, {60'h0, e.cnt[3:0]});
        @(posedge clk);
        if (v.v && v.rw && v.rd != 5'd0) mregs[v.rd] = v.exp_res;
        if (v.v) mcnt = mcnt + 64'd1;
        #1;
    endtask

    task automatic reset_scan(input string tag);
        for (int i = 0; i < 32; i++) begin
            RS1D = 5'(i);
            RS2D = 5'(31 - i);
            #1;
            chk({tag, ".rd1"}, {32'h0, RD1D}, 64'h0);
            chk({tag, ".rd2"}, {32'h0, RD2D}, 64'h0);
        end
        chk({tag, ".cnt"}, InstRetW, 64'h0);
        chk({tag, ".cnt4"}, {60'h0, s_cnt}, 64'h0);
    endtask

    initial begin
        vec_t cv;
        rst = 1'b0; ValidW = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'b00;
        Adder4W = '0; ALUResultW = '0; ReadDataW = '0; RDW = '0; RS1D = '0; RS2D = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        reset_scan("por");

        //            name        v  rw src    adder4        alu           rdata         rd rs1 rs2 exp_res
        vecs.push_back('{"wr_x5",  1, 1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1111_1111, 5,  5,  0, 32'hDEAD_BEEF});
        vecs.push_back('{"rd_x5",  0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,  5,  0, 32'h0});
        vecs.push_back('{"ld_x7",  1, 1, 2'b01, 32'h0000_0020, 32'h2222_2222, 32'h1234_5678, 7,  5,  7, 32'h1234_5678});
        vecs.push_back('{"pc4_x1", 1, 1, 2'b10, 32'h0000_0104, 32'h3333_3333, 32'h4444_4444, 1,  7,  1, 32'h0000_0104});
        vecs.push_back('{"rsv_x2", 1, 1, 2'b11, 32'h5555_5555, 32'h0BAD_F00D, 32'h6666_6666, 2,  1,  2, 32'h0BAD_F00D});
        vecs.push_back('{"wr_x0",  1, 1, 2'b00, 32'h0,         32'hFFFF_FFFF, 32'h0,         0,  0,  2, 32'hFFFF_FFFF});
        vecs.push_back('{"rd_x0",  1, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,  0,  0, 32'h0});
        vecs.push_back('{"bub_x3", 0, 1, 2'b00, 32'h0,         32'hCAFE_0003, 32'h0,         3,  3,  3, 32'hCAFE_0003});
        vecs.push_back('{"rd_x3",  0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,  3,  1, 32'h0});
        vecs.push_back('{"x9_one", 1, 1, 2'b00, 32'h0,         32'h0000_0001, 32'h0,         9,  0,  9, 32'h0000_0001});
        vecs.push_back('{"x9_byp", 1, 1, 2'b01, 32'h0,         32'h0,         32'hA5A5_A5A5, 9,  9,  9, 32'hA5A5_A5A5});
        vecs.push_back('{"x9_new", 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,  9,  9, 32'h0});
        vecs.push_back('{"x31",    1, 1, 2'b00, 32'h0,         32'h8000_0001, 32'h0,         31, 31, 5, 32'h8000_0001});
        vecs.push_back('{"rd_all", 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,  31, 7, 32'h0});
        foreach (vecs[i]) apply(vecs[i]);

        // Reset asserted mid-cycle must block the pending write and clear state.
        ValidW = 1'b1; RegWriteW = 1'b1; ResultSrcW = 2'b00; ALUResultW = 32'h0000_0777; RDW = 5'd12;
        #3 rst = 1'b0;
        model_clear();
        ValidW = 1'b0;
        reset_scan("midrst");
        ValidW = 1'b1; RS1D = 5'd12; RS2D = 5'd0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        mregs[12] = 32'h0000_0777; mcnt = 64'd1;
        ValidW = 1'b0;
        #1;
        chk("first_wr.rd1", {32'h0, RD1D}, 64'h777);
        chk("first_wr.cnt", InstRetW, 64'd1);

        // Counter: 10 valid interleaved with 3 bubbles, then 7 more for the 4-bit wrap.
        rst = 1'b0; #2 rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
        for (int i = 0; i < 13; i++) begin
            cv = '{"cnt_a", (i % 4) != 3, 0, 2'b00, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0};
            apply(cv);
        end
        chk("cnt10", InstRetW, 64'd10);
        chk("cnt10_w4", {60'h0, s_cnt}, 64'd10);
        for (int i = 0; i < 7; i++) begin
            cv = '{"cnt_b", 1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0};
            apply(cv);
        end
        chk("cnt17", InstRetW, 64'd17);
        chk("cnt17_wrap", {60'h0, s_cnt}, 64'd1);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
